a10_sata_recfg_responder: RTL and testbench

//  Responder end of the transceiver reconfiguration register interface that
//  a10_sata_xcvr_reconf drives. Implements CTRL (0x340) and STAT (0x341).
//  On a CFG_LOAD write it streams the selected SATA profile from an external

---
 rtl/a10_sata_recfg_responder.sv | 160 ++++++++++++++++
 tb/tb_a10_sata_recfg_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/a10_sata_recfg_responder.sv
// Responder for the SATA transceiver reconfiguration register interface.
// Exposes CTRL (0x340) and STAT (0x341). A CFG_LOAD write streams one profile
// from an external ROM into the DPRIO port as masked read-modify-writes.
module a10_sata_recfg_responder #(
  parameter int PROFILES = 3,
  parameter int WORDS    = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [9:0]                          recfg_addr,
  input  logic                                recfg_wreq,
  input  logic [31:0]                         recfg_wdat,
  input  logic                                recfg_rreq,
  output logic [31:0]                         recfg_rdat,
  output logic                                recfg_busy,
  output logic [$clog2(PROFILES*WORDS)-1:0]   rom_addr,
  input  logic [73:0]                         rom_data,
  output logic [9:0]                          xcvr_addr,
  output logic                                xcvr_read,
  output logic                                xcvr_write,
  output logic [31:0]                         xcvr_wdat,
  input  logic [31:0]                         xcvr_rdat,
  input  logic                                xcvr_waitreq
);

  localparam int AW = $clog2(PROFILES*WORDS);
  localparam int IW = $clog2(WORDS);
  localparam logic [9:0] CTRL_ADDR = 10'h340;
  localparam logic [9:0] STAT_ADDR = 10'h341;
  localparam logic [9:0] END_MARK  = 10'h3FF;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_LATCH, ST_RD, ST_WR, ST_DONE
  } state_t;

  state_t          state, state_next;
  logic            ack;
  logic [6:0]      ctrl;
  logic            stat_busy;
  logic            stat_err;
  logic [2:0]      sel;
  logic [IW-1:0]   idx;
  logic [9:0]      ent_addr;
  logic [31:0]     ent_mask;
  logic [31:0]     ent_data;
  logic [31:0]     wd;
  logic            req;
  logic            wr_commit;
  logic            load_req;
  logic            sel_ok;
  logic            start;
  logic            last_word;
  logic            unused;

  // Every access completes on its second cycle; ack alternates so that
  // back-to-back requests each see one busy cycle.
  assign req        = recfg_wreq | recfg_rreq;
  assign wr_commit  = recfg_wreq & ack;
  assign load_req   = wr_commit & (recfg_addr == CTRL_ADDR) & recfg_wdat[7];
  assign sel_ok     = ({29'b0, recfg_wdat[2:0]} < $unsigned(PROFILES));
  assign start      = load_req & sel_ok & (state == ST_IDLE);
  assign last_word  = (idx == IW'(WORDS - 1));
  assign recfg_busy = reset & req & ~ack;
  assign unused     = ^recfg_wdat[31:8];

  // Register read mux; a simultaneous write suppresses read data.
  always_comb begin
    recfg_rdat = '0;
    if (reset && recfg_rreq && !recfg_wreq && ack) begin
      case (recfg_addr)
        CTRL_ADDR: recfg_rdat = {24'b0, 1'b0, ctrl};
        STAT_ADDR: recfg_rdat = {29'b0, stat_err, 1'b0, stat_busy};
        default:   recfg_rdat = '0;
      endcase
    end
  end

  // Control registers: access handshake, CTRL/STAT, profile select, word index.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ack       <= 1'b0;
      ctrl      <= '0;
      stat_busy <= 1'b0;
      stat_err  <= 1'b0;
      sel       <= '0;
      idx       <= '0;
    end else begin
      ack <= req ? ~ack : 1'b0;
      if (wr_commit && recfg_addr == CTRL_ADDR) begin
        if (!recfg_wdat[7]) begin
          ctrl <= recfg_wdat[6:0];
        end else if (state != ST_IDLE) begin
          stat_err <= 1'b1;
        end else if (!sel_ok) begin
          ctrl     <= recfg_wdat[6:0];
          stat_err <= 1'b1;
        end else begin
          ctrl      <= recfg_wdat[6:0];
          sel       <= recfg_wdat[2:0];
          stat_busy <= 1'b1;
          stat_err  <= 1'b0;
        end
      end
      if (state == ST_DONE) stat_busy <= 1'b0;
      if (start) begin
        idx <= '0;
      end else if (state == ST_WR && !xcvr_waitreq && !last_word) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Profile entry and merged write-back word; pure datapath, no reset.
  always_ff @(posedge clk) begin
    if (state == ST_LATCH) begin
      {ent_addr, ent_mask, ent_data} <= rom_data;
    end
    if (state == ST_RD && !xcvr_waitreq) begin
      wd <= (xcvr_rdat & ~ent_mask) | (ent_data & ent_mask);
    end
  end

  // Stream FSM state register; reset aborts any DPRIO transaction at once.
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Stream FSM next state and DPRIO/ROM strobes; read and write never overlap.
  always_comb begin
    state_next = state;
    rom_addr   = '0;
    xcvr_addr  = '0;
    xcvr_read  = 1'b0;
    xcvr_write = 1'b0;
    xcvr_wdat  = '0;
    case (state)
      ST_IDLE:  if (start) state_next = ST_FETCH;
      ST_FETCH: begin
        rom_addr   = AW'(sel) * AW'(WORDS) + AW'(idx);
        state_next = ST_LATCH;
      end
      ST_LATCH: state_next = (rom_data[73:64] == END_MARK) ? ST_DONE : ST_RD;
      ST_RD: begin
        xcvr_addr = ent_addr;
        xcvr_read = 1'b1;
        if (!xcvr_waitreq) state_next = ST_WR;
      end
      ST_WR: begin
        xcvr_addr  = ent_addr;
        xcvr_write = 1'b1;
        xcvr_wdat  = wd;
        if (!xcvr_waitreq) state_next = last_word ? ST_DONE : ST_FETCH;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_a10_sata_recfg_responder.sv
// Directed bench for a10_sata_recfg_responder with a ROM and DPRIO model.
module tb_a10_sata_recfg_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  recfg_addr;
  logic        recfg_wreq;
  logic [31:0] recfg_wdat;
  logic        recfg_rreq;
  logic [31:0] recfg_rdat;
  logic        recfg_busy;
  logic [4:0]  rom_addr;
  logic [73:0] rom_data;
  logic [9:0]  xcvr_addr;
  logic        xcvr_read;
  logic        xcvr_write;
  logic [31:0] xcvr_wdat;
  logic [31:0] xcvr_rdat;
  logic        xcvr_waitreq;

  logic [73:0] rom [0:31];
  logic        stall_en;
  logic        hold_wait;
  logic        phase;
  int          n_wr;
  int          n_rd;
  logic        overlap;
  logic [9:0]  wr_addr_log [0:255];
  logic [31:0] wr_dat_log  [0:255];
  logic [9:0]  rd_addr_log [0:255];

  int checks = 0;
  int errors = 0;

  a10_sata_recfg_responder #(.PROFILES(3), .WORDS(8)) dut (
    .clk(clk), .reset(reset),
    .recfg_addr(recfg_addr), .recfg_wreq(recfg_wreq), .recfg_wdat(recfg_wdat),
    .recfg_rreq(recfg_rreq), .recfg_rdat(recfg_rdat), .recfg_busy(recfg_busy),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .xcvr_addr(xcvr_addr), .xcvr_read(xcvr_read), .xcvr_write(xcvr_write),
    .xcvr_wdat(xcvr_wdat), .xcvr_rdat(xcvr_rdat), .xcvr_waitreq(xcvr_waitreq)
  );

  always #5 clk = ~clk;

  // ROM with one-cycle read latency.
  always @(posedge clk) rom_data <= rom[rom_addr];

  // DPRIO model: optional one wait cycle per transaction, or a stuck write.
  always @(posedge clk) phase <= (xcvr_read | xcvr_write) ? ~phase : 1'b0;
  assign xcvr_waitreq = (hold_wait & xcvr_write) |
                        (stall_en & (xcvr_read | xcvr_write) & ~phase);

  // Transaction log of accepted DPRIO reads and writes.
  always @(posedge clk) begin
    if (reset && xcvr_write && !xcvr_waitreq) begin
      wr_addr_log[n_wr[7:0]] <= xcvr_addr;
      wr_dat_log[n_wr[7:0]]  <= xcvr_wdat;
      n_wr <= n_wr + 1;
    end
    if (reset && xcvr_read && !xcvr_waitreq) begin
      rd_addr_log[n_rd[7:0]] <= xcvr_addr;
      n_rd <= n_rd + 1;
    end
    if (xcvr_read && xcvr_write) overlap <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One register access starting at a negedge; returns read data and cycle count.
  task automatic access(input logic we, input logic re, input logic [9:0] a,
                        input logic [31:0] d, output logic [31:0] q, output int cyc);
    recfg_addr = a; recfg_wdat = d; recfg_wreq = we; recfg_rreq = re;
    cyc = 1;
    #1;
    while (recfg_busy && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    q = recfg_rdat;
    @(posedge clk);
    #1;
    recfg_wreq = 1'b0; recfg_rreq = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input string tag, input logic [9:0] a, input logic [31:0] d);
    logic [31:0] q;
    int cyc;
    access(1'b1, 1'b0, a, d, q, cyc);
    check(tag, 32'(cyc), 32'd2);
  endtask

  task automatic rd(input string tag, input logic [9:0] a, output logic [31:0] q);
    int cyc;
    access(1'b0, 1'b1, a, 32'h0, q, cyc);
    check(tag, 32'(cyc), 32'd2);
  endtask

  // Poll STAT until the stream reports idle, bounded.
  task automatic wait_idle(output logic [31:0] q);
    int n;
    n = 0;
    do begin
      rd("poll_cyc", 10'h341, q);
      n++;
    end while (q[0] && n < 100);
  endtask

  initial begin
    logic [31:0] q;
    int base_wr, base_rd, cyc, k;

    for (int i = 0; i < 32; i++) rom[i] = '0;
    rom[0] = {10'h010, 32'h00000000, 32'hDEADBEEF};
    rom[1] = {10'h011, 32'hFFFFFFFF, 32'hCAFEF00D};
    rom[2] = {10'h3FF, 32'h0, 32'h0};
    for (int i = 3; i < 8; i++) rom[i] = {10'(32'h10 + i), 32'h1, 32'h1};
    for (int i = 0; i < 8; i++) rom[8 + i]  = {10'(32'h100 + i), 32'h0000FF00, 32'h00001200};
    for (int i = 0; i < 8; i++) rom[16 + i] = {10'(32'h200 + i), 32'hF0F0F0F0, 32'h00000000};

    reset = 1'b0; recfg_addr = '0; recfg_wreq = 1'b0; recfg_wdat = '0; recfg_rreq = 1'b0;
    xcvr_rdat = 32'hFFFF0000; stall_en = 1'b1; hold_wait = 1'b0;
    n_wr = 0; n_rd = 0; overlap = 1'b0; phase = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy",  {31'b0, recfg_busy}, 32'h0);
    check("rst_rdat",  recfg_rdat, 32'h0);
    check("rst_strobe", {30'b0, xcvr_read, xcvr_write}, 32'h0);
    check("rst_romaddr", {27'b0, rom_addr}, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    rd("stat0_cyc", 10'h341, q);
    check("stat0", q, 32'h0);

    // Profile 1, full 8-entry stream with wait states
    base_wr = n_wr; base_rd = n_rd;
    wr("load81_cyc", 10'h340, 32'h81);
    rd("stat_run_cyc", 10'h341, q);
    check("stat_running", q, 32'h1);
    rd("ctrl_cyc", 10'h340, q);
    check("ctrl_read", q, 32'h01);
    wait_idle(q);
    check("stat_after_p1", q, 32'h0);
    check("p1_nwr", 32'(n_wr - base_wr), 32'd8);
    check("p1_nrd", 32'(n_rd - base_rd), 32'd8);
    check("p1_rd_addr0", {22'b0, rd_addr_log[base_rd]}, 32'h100);
    check("p1_wr_addr0", {22'b0, wr_addr_log[base_wr]}, 32'h100);
    check("p1_wr_addr7", {22'b0, wr_addr_log[base_wr + 7]}, 32'h107);
    check("p1_wdat0", wr_dat_log[base_wr], 32'hFFFF1200);
    check("p1_wdat7", wr_dat_log[base_wr + 7], 32'hFFFF1200);

    // Profile 0 with end marker at entry 2; mask=0 and mask=all-ones entries
    xcvr_rdat = 32'h12345678; stall_en = 1'b0;
    base_wr = n_wr;
    wr("load80_cyc", 10'h340, 32'h80);
    wait_idle(q);
    check("stat_after_p0", q, 32'h0);
    check("p0_nwr", 32'(n_wr - base_wr), 32'd2);
    check("p0_wdat_mask0", wr_dat_log[base_wr], 32'h12345678);
    check("p0_wdat_maskff", wr_dat_log[base_wr + 1], 32'hCAFEF00D);
    check("p0_wr_addr1", {22'b0, wr_addr_log[base_wr + 1]}, 32'h011);

    // Out-of-range select
    base_rd = n_rd;
    wr("load83_cyc", 10'h340, 32'h83);
    rd("stat_bad_cyc", 10'h341, q);
    check("stat_badsel", q, 32'h4);
    repeat (10) @(negedge clk);
    check("badsel_no_dprio", 32'(n_rd - base_rd), 32'd0);

    // Second load during a stream is rejected; stream still completes
    xcvr_rdat = 32'hFFFF0000; stall_en = 1'b1;
    base_wr = n_wr;
    wr("load82_cyc", 10'h340, 32'h82);
    rd("stat_p2_cyc", 10'h341, q);
    check("stat_p2_errclr", q, 32'h1);
    wr("load81_mid_cyc", 10'h340, 32'h81);
    rd("stat_mid_cyc", 10'h341, q);
    check("stat_mid_err", q, 32'h5);
    wait_idle(q);
    check("stat_after_p2", q, 32'h4);
    check("p2_nwr", 32'(n_wr - base_wr), 32'd8);
    check("p2_wr_addr7", {22'b0, wr_addr_log[base_wr + 7]}, 32'h207);
    check("p2_wdat7", wr_dat_log[base_wr + 7], 32'h0F0F0000);
    wr("load80b_cyc", 10'h340, 32'h80);
    rd("stat_p0b_cyc", 10'h341, q);
    check("stat_err_cleared", q, 32'h1);
    wait_idle(q);
    check("stat_after_p0b", q, 32'h0);

    // Unmapped addresses, STAT write ignored, write wins over read
    rd("unmapped_cyc", 10'h123, q);
    check("unmapped_rd", q, 32'h0);
    wr("statwr_cyc", 10'h341, 32'hFFFFFFFF);
    rd("stat_wr_ign_cyc", 10'h341, q);
    check("stat_wr_ignored", q, 32'h0);
    access(1'b1, 1'b1, 10'h340, 32'h05, q, cyc);
    check("wr_rd_cyc", 32'(cyc), 32'd2);
    check("wr_rd_rdat", q, 32'h0);
    rd("ctrl2_cyc", 10'h340, q);
    check("ctrl_after_wr_rd", q, 32'h05);
    check("no_overlap", {31'b0, overlap}, 32'h0);

    // Reset during a stalled DPRIO write
    stall_en = 1'b0; hold_wait = 1'b1;
    wr("load81_rst_cyc", 10'h340, 32'h81);
    k = 0;
    while (!xcvr_write && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("saw_stuck_write", {31'b0, xcvr_write}, 32'h1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_strobes", {30'b0, xcvr_read, xcvr_write}, 32'h0);
    check("rst_mid_busy", {31'b0, recfg_busy}, 32'h0);
    @(negedge clk);
    reset = 1'b1; hold_wait = 1'b0;
    rd("stat_postrst_cyc", 10'h341, q);
    check("stat_postrst", q, 32'h0);
    rd("ctrl_postrst_cyc", 10'h340, q);
    check("ctrl_postrst", q, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
